// File: rtl/branch_target_predictor_pkg.sv
// Shared types and elaboration-time helpers for the branch target buffer and
// any later predictors built beside it.
package branch_target_predictor_pkg;

    typedef logic [31:0] word_t;

    // Index width derived from the entry count; ENTRIES is a power of two >= 2.
    function automatic int btb_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Tag covers every PC bit above the index and the ignored byte offset.
    function automatic int btb_tag_w(input int entries);
        return 32 - $clog2(entries) - 2;
    endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter.sv
// Saturating up/down counter step: computes the next value from the current one
// without holding any state itself.
module sat_counter #(
    parameter int W = 2
) (
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] cur,
    output logic [W-1:0] nxt
);

    localparam logic [W-1:0] MAX_VAL = '1;
    localparam logic [W-1:0] MIN_VAL = '0;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        nxt = cur;
        if (inc && !dec && cur != MAX_VAL) begin
            nxt = cur + W'(1);
        end else if (dec && !inc && cur != MIN_VAL) begin
            nxt = cur - W'(1);
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters; combinational lookup for IF, resolved-branch updates from MEM.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      lookup_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_en,
    input  logic             upd_stall,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = btb_idx_w(ENTRIES);
    localparam int TAG_W = btb_tag_w(ENTRIES);

    // New entries start weakly taken: only the counter MSB set.
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [CTR_W-1:0] ctr;
    } entry_t;

    entry_t table_q [ENTRIES];

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    entry_t           lookup_entry;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    entry_t           upd_entry;
    logic             upd;
    logic             upd_hit;
    logic [CTR_W-1:0] ctr_nxt;

    // The two low PC bits never select anything; they are tied off here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Lookup path: pure read of the current array contents, no bypass.
    assign lookup_idx   = lookup_pc[IDX_W+1:2];
    assign lookup_tag   = lookup_pc[31:IDX_W+2];
    assign lookup_entry = table_q[lookup_idx];

    always_comb begin
        pred_hit    = lookup_entry.valid && (lookup_entry.tag == lookup_tag);
        pred_taken  = pred_hit && lookup_entry.ctr[CTR_W-1];
        pred_target = pred_hit ? lookup_entry.target : 32'h0;
    end

    // Update path.
    assign upd       = upd_en && !upd_stall;
    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[31:IDX_W+2];
    assign upd_entry = table_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    // A correct direction with a wrong target still counts as a mispredict.
    always_comb begin
        mispredict = 1'b0;
        if (upd) begin
            mispredict = (upd_taken != upd_pred_taken) ||
                         (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));
        end
    end

    sat_counter #(
        .W (CTR_W)
    ) u_dir_ctr (
        .inc (upd_taken),
        .dec (!upd_taken),
        .cur (upd_entry.ctr),
        .nxt (ctr_nxt)
    );

    // NOTE: the flop-based array is fully cleared on reset because a stale valid bit
    // would produce hits; this is affordable only because there is no SRAM behind it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (upd) begin
            if (upd_hit) begin
                // NOTE: sequential state uses non-blocking assignments so every reader
                // in this edge sees the pre-edge value.
                table_q[upd_idx].ctr <= ctr_nxt;
                if (upd_taken) begin
                    table_q[upd_idx].target <= upd_target;
                end
            end else if (upd_taken) begin
                // Aliasing taken branch evicts whatever lives at this index.
                table_q[upd_idx] <= '{valid:  1'b1,
                                      tag:    upd_tag,
                                      target: upd_target,
                                      ctr:    CTR_WEAK};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (upd) begin
            branch_count <= branch_count + CNT_W'(1);
            if (mispredict) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a table-of-integers reference model of the predictor.
module tb_branch_target_predictor;

    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 4;
    localparam int CTR_MAX = (1 << CTR_W) - 1;
    localparam int CTR_MID = 1 << (CTR_W - 1);

    logic             clk;
    logic             rst;
    logic [31:0]      lookup_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             upd_en;
    logic             upd_stall;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic             upd_pred_taken;
    logic [31:0]      upd_pred_target;
    logic             mispredict;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    branch_target_predictor #(
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK              (clk),
        .RST              (rst),
        .lookup_pc        (lookup_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_en           (upd_en),
        .upd_stall        (upd_stall),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .mispredict       (mispredict),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per index, plain integers.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int unsigned m_branches;
    int unsigned m_mispredicts;

    int n_vec;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pc_index(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned pc_tag(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 32'h0;
            m_ctr[i]    = 0;
        end
        m_branches    = 0;
        m_mispredicts = 0;
    endtask

    // One clock cycle: drive, check the combinational view, clock, advance model.
    task automatic step(input logic [31:0] lpc, input logic en, input logic stall,
                        input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                        input logic ptaken, input logic [31:0] ptgt, input logic do_rst);
        int  li, ui;
        bit  lhit, uhit, upd, mis;
        lookup_pc       = lpc;
        upd_en          = en;
        upd_stall       = stall;
        upd_pc          = pc;
        upd_taken       = taken;
        upd_target      = tgt;
        upd_pred_taken  = ptaken;
        upd_pred_target = ptgt;
        rst             = do_rst;
        #4;
        li   = pc_index(lpc);
        lhit = m_valid[li] && (m_tag[li] == pc_tag(lpc));
        upd  = en && !stall;
        mis  = upd && ((taken != ptaken) || (taken && ptaken && tgt != ptgt));
        check("pred_hit",    {31'b0, pred_hit},   {31'b0, lhit});
        check("pred_taken",  {31'b0, pred_taken}, {31'b0, lhit && m_ctr[li] >= CTR_MID});
        check("pred_target", pred_target,         lhit ? m_target[li] : 32'h0);
        check("mispredict",  {31'b0, mispredict}, {31'b0, mis});
        check("branch_count",     32'(branch_count),     m_branches % (1 << CNT_W));
        check("mispredict_count", 32'(mispredict_count), m_mispredicts % (1 << CNT_W));
        @(posedge clk);
        if (do_rst) begin
            model_clear();
        end else if (upd) begin
            m_branches++;
            if (mis) m_mispredicts++;
            ui   = pc_index(pc);
            uhit = m_valid[ui] && (m_tag[ui] == pc_tag(pc));
            if (uhit) begin
                if (taken) begin
                    m_ctr[ui]    = (m_ctr[ui] < CTR_MAX) ? m_ctr[ui] + 1 : CTR_MAX;
                    m_target[ui] = tgt;
                end else begin
                    m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                end
            end else if (taken) begin
                m_valid[ui]  = 1'b1;
                m_tag[ui]    = pc_tag(pc);
                m_target[ui] = tgt;
                m_ctr[ui]    = CTR_MID;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] lpc);
        step(lpc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic branch(input logic [31:0] lpc, input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic ptaken);
        step(lpc, 1'b1, 1'b0, pc, taken, tgt, ptaken, tgt, 1'b0);
    endtask

    logic [31:0] pool [6];

    function automatic logic [31:0] pick_pc();
        logic [31:0] p;
        p = pool[$urandom_range(0, 5)];
        return {p[31:2], 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        n_vec  = 0;
        n_fail = 0;
        model_clear();
        lookup_pc = 0; upd_en = 0; upd_stall = 0; upd_pc = 0; upd_taken = 0;
        upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold lookup after reset.
        idle(32'h40);
        // First taken branch allocates; predicted not-taken so it mispredicts.
        branch(32'h40, 32'h40, 1'b1, 32'h80, 1'b0);
        idle(32'h40);
        // Counter walks down and saturates at zero, then up and saturates at max.
        repeat (3) branch(32'h40, 32'h40, 1'b0, 32'h0, 1'b1);
        idle(32'h40);
        repeat (4) branch(32'h40, 32'h40, 1'b1, 32'h80, 1'b1);
        idle(32'h40);
        // Alias at the same index evicts the resident entry.
        branch(32'h40, 32'h40 + 4 * ENTRIES, 1'b1, 32'h200, 1'b1);
        idle(32'h40);
        idle(32'h40 + 4 * ENTRIES);
        // Stalled update is ignored; wrong-target prediction while stalled is not counted.
        step(32'h44, 1'b1, 1'b1, 32'h44, 1'b1, 32'h300, 1'b1, 32'h304, 1'b0);
        idle(32'h44);
        // Reset coinciding with an update discards it.
        step(32'h80, 1'b1, 1'b0, 32'h44, 1'b1, 32'h300, 1'b0, 32'h300, 1'b1);
        idle(32'h44);
        idle(32'h80);
        // 17 updates wrap the 4-bit counters; lookup shares the updated index.
        for (int i = 0; i < 17; i++) begin
            branch(32'h48, 32'h48, 1'b1, 32'h100 + 32'(i * 4), 1'b0);
        end
        idle(32'h48);

        // Random traffic over a small PC pool so hits, aliases and evictions recur.
        pool[0] = 32'h40;
        pool[1] = 32'h44;
        pool[2] = 32'h40 + 4 * ENTRIES;
        pool[3] = 32'h1000_0040;
        pool[4] = 32'h0000_0100;
        pool[5] = $urandom;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] tgt;
            tgt = {$urandom_range(0, 3) == 0 ? $urandom : 32'h400 + 32'($urandom_range(0, 3) * 4)};
            step(pick_pc(), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 pick_pc(), 1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 1) == 0 ? tgt : tgt + 32'h4,
                 $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised direct-mapped branch target buffer with per-entry saturating direction counters and mispredict statistics. Sits beside the IF stage of the pipelined datapath: IF presents the fetch PC and receives a same-cycle taken/target prediction; MEM reports each resolved BEQ/BNE back as an update. Replaces the fixed "always predict taken" branch-address path with learned direction and stored targets.

## Interface
Parameters:
- ENTRIES, 16: number of BTB entries; power of two, ≥ 2.
- CTR_W, 2: direction counter width, 1..4.
- CNT_W, 32: statistics counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- lookup_pc  in  32  fetch PC (word_t).
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  pred_hit and counter MSB = 1.
- pred_target  out  32  stored target when pred_hit, else 0.
- upd_en  in  1  one resolved conditional branch this cycle; qualified by upd_stall.
- upd_stall  in  1  MEM stalled (dhit miss); suppresses the update.
- upd_pc  in  32  PC of resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual taken target.
- upd_pred_taken  in  1  prediction carried down the pipe for this branch.
- upd_pred_target  in  32  predicted target carried down the pipe.
- mispredict  out  1  combinational; this update was mispredicted.
- branch_count  out  CNT_W  resolved branches since reset.
- mispredict_count  out  CNT_W  mispredicts since reset.

## Operation
- IDX_W = log2(ENTRIES). index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. pc[1:0] ignored.
- Entry = {valid, tag, target[31:0], ctr[CTR_W-1:0]}.
- Lookup is purely combinational on lookup_pc; no state change.
- Update fires when upd_en & !upd_stall (= "upd"):
  - Hit (valid & tag match): ctr saturating +1 if upd_taken (stops at 2^CTR_W−1), −1 if not taken (stops at 0). If upd_taken, target ← upd_target.
  - Miss, upd_taken = 1: allocate/overwrite entry: valid=1, tag, target=upd_target, ctr=2^(CTR_W−1) (weakly taken).
  - Miss, upd_taken = 0: no write.
- mispredict = upd & ((upd_taken ≠ upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target ≠ upd_pred_target)).
- branch_count += 1 on each upd; mispredict_count += 1 when mispredict. Both wrap modulo 2^CNT_W.
- Address target is stored full 32 bits; no truncation.

## Timing
- Lookup: 0-cycle latency, combinational from lookup_pc and array state.
- Update: written at the rising edge where upd is high; visible to lookup from the next cycle. Same-cycle lookup of the index being updated returns the old contents (no bypass).
- Counters change at the same edge as the update; mispredict valid only in the update cycle.
- Reset (RST high at edge, any time incl. mid-update): all valid=0, ctr=0, target=0, tag=0, both statistics counters 0; an update coinciding with reset is discarded. Post-reset outputs: pred_hit=0, pred_taken=0, pred_target=0, mispredict=0 (unless upd asserted), counts 0.
- upd_stall high: no array write, no count change, mispredict=0; the same branch is expected again on the unstalled cycle.
- Aliasing: a taken branch whose index matches a different tag evicts the resident entry unconditionally.

## Structure
- Add to cpu_types_pkg: btb_entry_t struct generic via parameters is not possible, so define BTB_IDX_W default-derivation helper function and word_t reuse there; the entry struct is declared locally using the module parameters.
- One sub-module: sat_counter (param W; inputs inc, dec, cur; output nxt) for the direction update, reusable by a later global-history predictor.
- Array is flip-flop based (ENTRIES × (1+tag+32+CTR_W)); no SRAM macro.

## Test plan
- Reset then lookup_pc=0x0000_0040 → pred_hit=0, pred_taken=0, pred_target=0, counts 0.
- Update pc=0x40 taken target=0x80 (pred_taken=0) → mispredict=1; next cycle lookup 0x40 → hit=1, taken=1, target=0x80; counts 1/1.
- Three not-taken updates to 0x40 (CTR_W=2) → ctr 2→1→0→0 saturates; lookup taken=0, hit=1; four taken updates → ctr saturates at 3.
- Alias: taken update pc=0x40 then taken update pc=0x40+4·ENTRIES target 0x200 → lookup 0x40 hit=0; lookup alias hit=1 target=0x200.
- upd_en=1 with upd_stall=1 → no array change, counts unchanged; assert RST during an update → all state cleared, update lost.
- Wrap: CNT_W=4, 17 updates → branch_count=1; same-cycle lookup/update of one index → lookup shows pre-update entry.
